// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, ALU-select and FSM-state definitions for the CPU control path.
// CPU_CTRL_EXT_OPS_EN adds the extended-op fields (bne strobe) to the decode record.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LOADI = 5'h00;
  localparam logic [4:0] OP_MOV   = 5'h01;
  localparam logic [4:0] OP_ADD   = 5'h02;
  localparam logic [4:0] OP_SUB   = 5'h03;
  localparam logic [4:0] OP_AND   = 5'h04;
  localparam logic [4:0] OP_OR    = 5'h05;
  localparam logic [4:0] OP_J     = 5'h06;
  localparam logic [4:0] OP_BEQ   = 5'h07;
  localparam logic [4:0] OP_LWD   = 5'h08;
  localparam logic [4:0] OP_LWI   = 5'h09;
  localparam logic [4:0] OP_SWD   = 5'h0A;
  localparam logic [4:0] OP_SWI   = 5'h0B;
  localparam logic [4:0] OP_MULT  = 5'h0C;
  localparam logic [4:0] OP_SLL   = 5'h0D;
  localparam logic [4:0] OP_SRL   = 5'h0E;
  localparam logic [4:0] OP_SRA   = 5'h0F;
  localparam logic [4:0] OP_BNE   = 5'h10;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EXEC = 2'd1;
  localparam state_t S_MEM  = 2'd2;
  localparam state_t S_WB   = 2'd3;

  typedef struct packed {
    logic       legal;
    logic [2:0] aluop;
    logic       muxcomp;
    logic       muximm;
    logic       reg_wr;
    logic       jump;
    logic       beq;
`ifdef CPU_CTRL_EXT_OPS_EN
    logic       bne;
`endif
    logic       mem;
    logic       load;
  } dec_t;

endpackage

// File: rtl/cpu_opcode_decode.sv
// Pure combinational opcode decode into a control record.
// CPU_CTRL_EXT_OPS_EN enables mult/sll/srl/sra/bne (0x0C-0x10); otherwise they decode illegal.
module cpu_opcode_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  always_comb begin
    dec       = '0;
    dec.legal = 1'b1;
    // Anything with bits set above bit 4 lies outside the opcode map.
    if ((opcode >> 5) != '0) begin
      dec.legal = 1'b0;
    end else begin
      case (opcode[4:0])
        OP_LOADI: begin dec.muximm = 1'b1; dec.reg_wr = 1'b1; end
        OP_MOV:   dec.reg_wr = 1'b1;
        OP_ADD:   begin dec.aluop = ALU_ADD; dec.reg_wr = 1'b1; end
        OP_SUB:   begin dec.aluop = ALU_ADD; dec.muxcomp = 1'b1; dec.reg_wr = 1'b1; end
        OP_AND:   begin dec.aluop = ALU_AND; dec.reg_wr = 1'b1; end
        OP_OR:    begin dec.aluop = ALU_OR;  dec.reg_wr = 1'b1; end
        OP_J:     dec.jump = 1'b1;
        OP_BEQ:   begin dec.aluop = ALU_ADD; dec.muxcomp = 1'b1; dec.beq = 1'b1; end
        OP_LWD:   begin dec.mem = 1'b1; dec.load = 1'b1; end
        OP_LWI:   begin dec.mem = 1'b1; dec.load = 1'b1; dec.muximm = 1'b1; end
        OP_SWD:   dec.mem = 1'b1;
        OP_SWI:   begin dec.mem = 1'b1; dec.muximm = 1'b1; end
`ifdef CPU_CTRL_EXT_OPS_EN
        OP_MULT:  begin dec.aluop = ALU_MUL; dec.reg_wr = 1'b1; end
        OP_SLL:   begin dec.aluop = ALU_SLL; dec.reg_wr = 1'b1; end
        OP_SRL:   begin dec.aluop = ALU_SRL; dec.reg_wr = 1'b1; end
        OP_SRA:   begin dec.aluop = ALU_SRA; dec.reg_wr = 1'b1; end
        OP_BNE:   begin dec.aluop = ALU_ADD; dec.muxcomp = 1'b1; dec.bne = 1'b1; end
`endif
        default:  dec.legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM (IDLE/EXEC/MEM/WB) with registered outputs and memory timeout.
// CPU_CTRL_EXT_OPS_EN enables extended ALU ops and the BNE_TRIGGER strobe.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW         = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           INSTR_VALID,
  input  logic [OPW-1:0] OPCODE,
  input  logic           BUSYWAIT,
  output logic [2:0]     ALUOP,
  output logic           MUXCOMP,
  output logic           MUXIMM,
  output logic           MUXDATAMEM,
  output logic           WRITEENABLE,
  output logic           J_TRIGGER,
  output logic           BEQ_TRIGGER,
  output logic           BNE_TRIGGER,
  output logic           READ,
  output logic           WRITE,
  output logic           PC_STALL,
  output logic           ILLEGAL
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  dec_t dec;

  cpu_opcode_decode #(.OPW(OPW)) u_dec (
    .opcode (OPCODE),
    .dec    (dec)
  );

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       load_q, load_d;
  logic [2:0] aluop_q, aluop_d;
  logic       muxcomp_q, muxcomp_d, muximm_q, muximm_d, muxdm_q, muxdm_d;
  logic       we_q, we_d, j_q, j_d, beq_q, beq_d;
  logic       rd_q, rd_d, wr_q, wr_d, stall_q, stall_d, ill_q, ill_d;
`ifdef CPU_CTRL_EXT_OPS_EN
  logic       bne_q, bne_d;
`endif

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    aluop_d   = aluop_q;
    muxcomp_d = muxcomp_q;
    muximm_d  = muximm_q;
    muxdm_d   = 1'b0;
    we_d      = 1'b0;
    j_d       = 1'b0;
    beq_d     = 1'b0;
`ifdef CPU_CTRL_EXT_OPS_EN
    bne_d     = 1'b0;
`endif
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    stall_d   = 1'b0;
    ill_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (INSTR_VALID) begin
          // Bad opcodes spend one EXEC cycle flagging ILLEGAL; mux selects keep old values.
          if (!dec.legal) begin
            state_d = S_EXEC;
            ill_d   = 1'b1;
          end else begin
            aluop_d   = dec.aluop;
            muxcomp_d = dec.muxcomp;
            muximm_d  = dec.muximm;
            if (dec.mem) begin
              state_d = S_MEM;
              cnt_d   = 8'd0;
              load_d  = dec.load;
              rd_d    = dec.load;
              wr_d    = !dec.load;
              stall_d = 1'b1;
            end else begin
              state_d = S_EXEC;
              we_d    = dec.reg_wr;
              j_d     = dec.jump;
              beq_d   = dec.beq;
`ifdef CPU_CTRL_EXT_OPS_EN
              bne_d   = dec.bne;
`endif
            end
          end
        end
      end
      S_EXEC: state_d = S_IDLE;
      S_MEM: begin
        if (!BUSYWAIT) begin
          if (load_q) begin
            state_d = S_WB;
            we_d    = 1'b1;
            muxdm_d = 1'b1;
            stall_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_inc == TMO) begin
          state_d = S_IDLE;
          cnt_d   = cnt_inc;
          ill_d   = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
          rd_d    = load_q;
          wr_d    = !load_q;
          stall_d = 1'b1;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      aluop_q   <= '0;
      muxcomp_q <= 1'b0;
      muximm_q  <= 1'b0;
      muxdm_q   <= 1'b0;
      we_q      <= 1'b0;
      j_q       <= 1'b0;
      beq_q     <= 1'b0;
`ifdef CPU_CTRL_EXT_OPS_EN
      bne_q     <= 1'b0;
`endif
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      stall_q   <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      aluop_q   <= aluop_d;
      muxcomp_q <= muxcomp_d;
      muximm_q  <= muximm_d;
      muxdm_q   <= muxdm_d;
      we_q      <= we_d;
      j_q       <= j_d;
      beq_q     <= beq_d;
`ifdef CPU_CTRL_EXT_OPS_EN
      bne_q     <= bne_d;
`endif
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      stall_q   <= stall_d;
      ill_q     <= ill_d;
    end
  end

  assign ALUOP       = aluop_q;
  assign MUXCOMP     = muxcomp_q;
  assign MUXIMM      = muximm_q;
  assign MUXDATAMEM  = muxdm_q;
  assign WRITEENABLE = we_q;
  assign J_TRIGGER   = j_q;
  assign BEQ_TRIGGER = beq_q;
`ifdef CPU_CTRL_EXT_OPS_EN
  assign BNE_TRIGGER = bne_q;
`else
  assign BNE_TRIGGER = 1'b0;
`endif
  assign READ        = rd_q;
  assign WRITE       = wr_q;
  assign PC_STALL    = stall_q;
  assign ILLEGAL     = ill_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed vector table, reset corner sequences, and random
// instructions checked against a transaction-level expected-output model.
module tb_cpu_control_fsm;
  localparam int OPW = 8;
  localparam int TMO = 4;

  logic           CLK = 1'b0;
  logic           RESET, INSTR_VALID, BUSYWAIT;
  logic [OPW-1:0] OPCODE;
  logic [2:0]     ALUOP;
  logic MUXCOMP, MUXIMM, MUXDATAMEM, WRITEENABLE, J_TRIGGER, BEQ_TRIGGER, BNE_TRIGGER;
  logic READ, WRITE, PC_STALL, ILLEGAL;

  always #5 CLK = ~CLK;

  cpu_control_fsm #(.OPW(OPW), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .BUSYWAIT(BUSYWAIT),
    .ALUOP(ALUOP), .MUXCOMP(MUXCOMP), .MUXIMM(MUXIMM), .MUXDATAMEM(MUXDATAMEM),
    .WRITEENABLE(WRITEENABLE), .J_TRIGGER(J_TRIGGER), .BEQ_TRIGGER(BEQ_TRIGGER),
    .BNE_TRIGGER(BNE_TRIGGER), .READ(READ), .WRITE(WRITE), .PC_STALL(PC_STALL), .ILLEGAL(ILLEGAL)
  );

  // field order: alu, mc, mi, mdm, we, j, beq, bne, rd, wr, stall, ill
  typedef struct packed {
    logic [2:0] alu;
    logic mc, mi, mdm, we, j, beq, bne, rd, wr, stall, ill;
  } out_t;

  typedef struct {
    logic [7:0] op;
    int         busy;
    out_t       exp;
  } vec_t;

  localparam int K_ILL = 0, K_REG = 1, K_J = 2, K_BEQ = 3, K_BNE = 4, K_LD = 5, K_ST = 6;

  int         n_chk = 0, n_pass = 0;
  logic [2:0] m_alu = 3'd0;
  logic       m_mc = 1'b0, m_mi = 1'b0;
  out_t       exp_q[$];
  bit         idl_q[$];
  vec_t       tbl[$];

  function automatic out_t actual();
    return {ALUOP, MUXCOMP, MUXIMM, MUXDATAMEM, WRITEENABLE, J_TRIGGER, BEQ_TRIGGER,
            BNE_TRIGGER, READ, WRITE, PC_STALL, ILLEGAL};
  endfunction

  task automatic check(input string name, input out_t want);
    out_t got;
    got = actual();
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic out_t idle_out();
    out_t o;
    o = '0;
    o.alu = m_alu; o.mc = m_mc; o.mi = m_mi;
    return o;
  endfunction

  task automatic ref_decode(input logic [7:0] op, output int kind, output logic [2:0] alu,
                            output logic mc, output logic mi);
    kind = K_ILL; alu = 3'd0; mc = 1'b0; mi = 1'b0;
    case (op)
      8'h00: begin kind = K_REG; mi = 1'b1; end
      8'h01: kind = K_REG;
      8'h02: begin kind = K_REG; alu = 3'd1; end
      8'h03: begin kind = K_REG; alu = 3'd1; mc = 1'b1; end
      8'h04: begin kind = K_REG; alu = 3'd2; end
      8'h05: begin kind = K_REG; alu = 3'd3; end
      8'h06: kind = K_J;
      8'h07: begin kind = K_BEQ; alu = 3'd1; mc = 1'b1; end
      8'h08: kind = K_LD;
      8'h09: begin kind = K_LD; mi = 1'b1; end
      8'h0A: kind = K_ST;
      8'h0B: begin kind = K_ST; mi = 1'b1; end
`ifdef CPU_CTRL_EXT_OPS_EN
      8'h0C, 8'h0D, 8'h0E, 8'h0F: begin kind = K_REG; alu = 3'(op - 8'h08); end
      8'h10: begin kind = K_BNE; alu = 3'd1; mc = 1'b1; end
`endif
      default: kind = K_ILL;
    endcase
  endtask

  // Expected per-cycle outputs after acceptance, given b cycles of BUSYWAIT high in MEM.
  task automatic build(input logic [7:0] op, input int b);
    int kind; logic [2:0] alu; logic mc, mi; out_t o;
    ref_decode(op, kind, alu, mc, mi);
    exp_q.delete(); idl_q.delete();
    if (kind == K_ILL) begin
      o = idle_out(); o.ill = 1'b1;
      exp_q.push_back(o); idl_q.push_back(1'b0);
      return;
    end
    m_alu = alu; m_mc = mc; m_mi = mi;
    o = idle_out();
    if (kind == K_LD || kind == K_ST) begin
      o.rd = (kind == K_LD); o.wr = (kind == K_ST); o.stall = 1'b1;
      if (b >= TMO) begin
        repeat (TMO) begin exp_q.push_back(o); idl_q.push_back(1'b0); end
        o = idle_out(); o.ill = 1'b1;
        exp_q.push_back(o); idl_q.push_back(1'b1);
      end else begin
        repeat (b + 1) begin exp_q.push_back(o); idl_q.push_back(1'b0); end
        if (kind == K_LD) begin
          o = idle_out(); o.we = 1'b1; o.mdm = 1'b1; o.stall = 1'b1;
          exp_q.push_back(o); idl_q.push_back(1'b0);
        end
      end
    end else begin
      o.we = (kind == K_REG); o.j = (kind == K_J); o.beq = (kind == K_BEQ); o.bne = (kind == K_BNE);
      exp_q.push_back(o); idl_q.push_back(1'b0);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
  task automatic run_instr(input logic [7:0] op, input int b, output out_t first);
    build(op, b);
    INSTR_VALID = 1'b1; OPCODE = op; BUSYWAIT = 1'($urandom % 2);
    first = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      if (i == 0) first = actual();
      check($sformatf("op%02h_b%0d_c%0d", op, b, i), exp_q[i]);
      BUSYWAIT    = (i < b);
      INSTR_VALID = idl_q[i] ? 1'b0 : 1'($urandom % 2);
      OPCODE      = OPW'($urandom);
    end
    @(negedge CLK);
    check($sformatf("op%02h_idle", op), idle_out());
    INSTR_VALID = 1'b0;
  endtask

  initial begin
    out_t first, o;
    logic [7:0] rop;

    tbl.push_back('{8'h02, 0, {3'd1, 11'b0_0_0_1_0_0_0_0_0_0_0}});  // add
    tbl.push_back('{8'h08, 3, {3'd0, 11'b0_0_0_0_0_0_0_1_0_1_0}});  // lwd, 4 READ cycles
    tbl.push_back('{8'h0B, 9, {3'd0, 11'b0_1_0_0_0_0_0_0_1_1_0}});  // swi, timeout
`ifdef CPU_CTRL_EXT_OPS_EN
    tbl.push_back('{8'h0D, 0, {3'd5, 11'b0_0_0_1_0_0_0_0_0_0_0}});  // sll
`else
    tbl.push_back('{8'h0D, 0, {3'd0, 11'b0_1_0_0_0_0_0_0_0_0_1}});  // illegal, swi muxes held
`endif
    tbl.push_back('{8'h03, 0, {3'd1, 11'b1_0_0_1_0_0_0_0_0_0_0}});  // sub
    tbl.push_back('{8'h07, 0, {3'd1, 11'b1_0_0_0_0_1_0_0_0_0_0}});  // beq
    tbl.push_back('{8'h06, 0, {3'd0, 11'b0_0_0_0_1_0_0_0_0_0_0}});  // j
    tbl.push_back('{8'h00, 0, {3'd0, 11'b0_1_0_1_0_0_0_0_0_0_0}});  // loadi
`ifdef CPU_CTRL_EXT_OPS_EN
    tbl.push_back('{8'h10, 0, {3'd1, 11'b1_0_0_0_0_0_1_0_0_0_0}});  // bne
`else
    tbl.push_back('{8'h10, 0, {3'd0, 11'b0_1_0_0_0_0_0_0_0_0_1}});  // illegal, loadi muxes held
`endif
    tbl.push_back('{8'h05, 0, {3'd3, 11'b0_0_0_1_0_0_0_0_0_0_0}});  // or
    tbl.push_back('{8'hFF, 0, {3'd3, 11'b0_0_0_0_0_0_0_0_0_0_1}});  // out of range
    tbl.push_back('{8'h09, 3, {3'd0, 11'b0_1_0_0_0_0_0_1_0_1_0}});  // lwi, just under timeout
    tbl.push_back('{8'h0A, 4, {3'd0, 11'b0_0_0_0_0_0_0_0_1_1_0}});  // swd, exactly timeout
    tbl.push_back('{8'h04, 0, {3'd2, 11'b0_0_0_1_0_0_0_0_0_0_0}});  // and
    tbl.push_back('{8'h01, 0, {3'd0, 11'b0_0_0_1_0_0_0_0_0_0_0}});  // mov
    tbl.push_back('{8'h1F, 0, {3'd0, 11'b0_0_0_0_0_0_0_0_0_0_1}});  // illegal

    RESET = 1'b0; INSTR_VALID = 1'b1; OPCODE = 8'h02; BUSYWAIT = 1'b1;
    repeat (2) begin @(negedge CLK); check("reset_hold", '0); end
    RESET = 1'b1; INSTR_VALID = 1'b0;
    @(negedge CLK); check("reset_release", '0);

    foreach (tbl[k]) begin
      run_instr(tbl[k].op, tbl[k].busy, first);
      n_chk++;
      if (first === tbl[k].exp) n_pass++;
      else $display("FAIL vec%0d_op%02h: got %h want %h", k, tbl[k].op, first, tbl[k].exp);
    end

    // Reset in MEM of lwi; INSTR_VALID in MEM must be ignored.
    INSTR_VALID = 1'b1; OPCODE = 8'h09; BUSYWAIT = 1'b1;
    @(negedge CLK); o = '0; o.mi = 1'b1; o.rd = 1'b1; o.stall = 1'b1; check("lwi_mem0", o);
    INSTR_VALID = 1'b1; OPCODE = 8'h02;
    @(negedge CLK); check("lwi_mem1_valid_ignored", o);
    RESET = 1'b0;
    @(negedge CLK); check("reset_in_mem", '0);
    RESET = 1'b1; INSTR_VALID = 1'b0; BUSYWAIT = 1'b0;
    @(negedge CLK); check("after_mem_reset", '0);

    // Reset in WB of lwd: no write-enable afterwards.
    INSTR_VALID = 1'b1; OPCODE = 8'h08; BUSYWAIT = 1'b0;
    @(negedge CLK); o = '0; o.rd = 1'b1; o.stall = 1'b1; check("lwd_mem", o);
    INSTR_VALID = 1'b0;
    @(negedge CLK); o = '0; o.we = 1'b1; o.mdm = 1'b1; o.stall = 1'b1; check("lwd_wb", o);
    RESET = 1'b0;
    @(negedge CLK); check("reset_in_wb", '0);
    RESET = 1'b1;
    @(negedge CLK); check("after_wb_reset", '0);
    m_alu = 3'd0; m_mc = 1'b0; m_mi = 1'b0;

    for (int n = 0; n < 200; n++) begin
      rop = ($urandom % 8 == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
      run_instr(rop, $urandom_range(0, 6), first);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
